// File: rtl/tx_queue_scheduler.sv
// rtl/tx_queue_scheduler.sv - round-robin TX queue scheduler for the shared MAC datapath
// Optional TX_SCHED_STATS_EN adds per-queue frame counters readable through stat_sel/stat_frames.
module tx_queue_scheduler #(
  parameter int NQ         = 4,
  parameter int QW         = 2,
  parameter int QUANTUM    = 4,
  parameter int MAX_RETRY  = 3,
  parameter int IFG_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [NQ-1:0] q_enable,
  input  logic [NQ-1:0] q_pending,
  output logic          sched_valid,
  output logic [QW-1:0] sched_qid,
  input  logic          sched_ready,
  input  logic          frame_done,
  input  logic          frame_underrun,
  output logic [NQ-1:0] grant,
  output logic          busy,
  output logic          underrun_abort,
  output logic          err_proto
`ifdef TX_SCHED_STATS_EN
  ,
  input  logic [QW-1:0] stat_sel,
  output logic [31:0]   stat_frames
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_ACTIVE, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic [3:0]    retry_cnt_q, retry_cnt_d;
  logic [7:0]    ifg_cnt_q, ifg_cnt_d;
  logic          sched_valid_q, sched_valid_d;
  logic [QW-1:0] sched_qid_q, sched_qid_d;
  logic [NQ-1:0] grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          underrun_abort_q, underrun_abort_d;
  logic          err_proto_q, err_proto_d;

  logic [NQ-1:0] eligible;
  logic [QW-1:0] sel_qid, cand;
  logic          sel_found, end_turn;

  assign eligible = q_enable & q_pending;

  // First eligible queue at or after rr_ptr; QW-bit add wraps modulo NQ.
  always_comb begin
    sel_qid   = rr_ptr_q;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NQ; i++) begin
      cand = rr_ptr_q + QW'(i);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_qid   = cand;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    burst_cnt_d      = burst_cnt_q;
    retry_cnt_d      = retry_cnt_q;
    ifg_cnt_d        = ifg_cnt_q;
    sched_valid_d    = sched_valid_q;
    sched_qid_d      = sched_qid_q;
    grant_d          = grant_q;
    underrun_abort_d = 1'b0;
    err_proto_d      = err_proto_q;
    end_turn         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          sched_qid_d   = sel_qid;
          sched_valid_d = 1'b1;
          burst_cnt_d   = '0;
          state_d       = S_OFFER;
        end
      end
      S_OFFER: begin
        // Ready wins over a simultaneous eligibility drop.
        if (sched_ready) begin
          sched_valid_d = 1'b0;
          grant_d       = {{(NQ-1){1'b0}}, 1'b1} << sched_qid_q;
          retry_cnt_d   = '0;
          state_d       = S_ACTIVE;
        end else if (!eligible[sched_qid_q]) begin
          sched_valid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (frame_done) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          if ((burst_cnt_q + 8'd1 < 8'(QUANTUM)) && eligible[sched_qid_q]) begin
            grant_d       = '0;
            sched_valid_d = 1'b1;
            state_d       = S_OFFER;
          end else begin
            end_turn = 1'b1;
          end
        end else if (frame_underrun) begin
          retry_cnt_d = retry_cnt_q + 4'd1;
          if (!(retry_cnt_q + 4'd1 < 4'(MAX_RETRY))) begin
            underrun_abort_d = 1'b1;
            burst_cnt_d      = burst_cnt_q + 8'd1;
            end_turn         = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (ifg_cnt_q == 8'd0) state_d = S_IDLE;
        else                   ifg_cnt_d = ifg_cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (end_turn) begin
      grant_d   = '0;
      rr_ptr_d  = sched_qid_q + QW'(1);
      ifg_cnt_d = 8'(IFG_CYCLES);
      state_d   = S_GAP;
    end

    if (((frame_done || frame_underrun) && state_q != S_ACTIVE) || (frame_done && frame_underrun))
      err_proto_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      rr_ptr_q         <= '0;
      burst_cnt_q      <= '0;
      retry_cnt_q      <= '0;
      ifg_cnt_q        <= '0;
      sched_valid_q    <= 1'b0;
      sched_qid_q      <= '0;
      grant_q          <= '0;
      busy_q           <= 1'b0;
      underrun_abort_q <= 1'b0;
      err_proto_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      burst_cnt_q      <= burst_cnt_d;
      retry_cnt_q      <= retry_cnt_d;
      ifg_cnt_q        <= ifg_cnt_d;
      sched_valid_q    <= sched_valid_d;
      sched_qid_q      <= sched_qid_d;
      grant_q          <= grant_d;
      busy_q           <= busy_d;
      underrun_abort_q <= underrun_abort_d;
      err_proto_q      <= err_proto_d;
    end
  end

  assign sched_valid    = sched_valid_q;
  assign sched_qid      = sched_qid_q;
  assign grant          = grant_q;
  assign busy           = busy_q;
  assign underrun_abort = underrun_abort_q;
  assign err_proto      = err_proto_q;

`ifdef TX_SCHED_STATS_EN
  logic [31:0] stat_cnt_q [NQ];
  logic [31:0] stat_cnt_d [NQ];
  logic [31:0] stat_frames_q, stat_frames_d;

  // Aborted frames are not counted; only real completions.
  always_comb begin
    for (int i = 0; i < NQ; i++) stat_cnt_d[i] = stat_cnt_q[i];
    if (state_q == S_ACTIVE && frame_done)
      stat_cnt_d[sched_qid_q] = stat_cnt_q[sched_qid_q] + 32'd1;
    stat_frames_d = stat_cnt_q[stat_sel];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NQ; i++) stat_cnt_q[i] <= '0;
      stat_frames_q <= '0;
    end else begin
      for (int i = 0; i < NQ; i++) stat_cnt_q[i] <= stat_cnt_d[i];
      stat_frames_q <= stat_frames_d;
    end
  end

  assign stat_frames = stat_frames_q;
`endif

endmodule

// File: tb/tb_tx_queue_scheduler.sv
// tb/tb_tx_queue_scheduler.sv - self-checking bench for tx_queue_scheduler
// Reference model tracks the round-robin pointer, per-turn frame quota and retry budget.
module tb_tx_queue_scheduler;
  localparam int NQ = 4, QW = 2, QUANTUM = 4, MAX_RETRY = 3, IFG_CYCLES = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NQ-1:0] q_enable = '0, q_pending = '0;
  logic          sched_ready = 1'b0, frame_done = 1'b0, frame_underrun = 1'b0;
  logic          sched_valid, busy, underrun_abort, err_proto;
  logic [QW-1:0] sched_qid;
  logic [NQ-1:0] grant;
`ifdef TX_SCHED_STATS_EN
  logic [QW-1:0] stat_sel = '0;
  logic [31:0]   stat_frames;
`endif

  int total = 0;
  int bad = 0;
  int m_rr = 0;
  int m_frames [NQ];

  always #5 clk = ~clk;

  tx_queue_scheduler #(.NQ(NQ), .QW(QW), .QUANTUM(QUANTUM), .MAX_RETRY(MAX_RETRY),
                       .IFG_CYCLES(IFG_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .q_enable(q_enable), .q_pending(q_pending),
    .sched_valid(sched_valid), .sched_qid(sched_qid), .sched_ready(sched_ready),
    .frame_done(frame_done), .frame_underrun(frame_underrun), .grant(grant), .busy(busy),
    .underrun_abort(underrun_abort), .err_proto(err_proto)
`ifdef TX_SCHED_STATS_EN
    , .stat_sel(stat_sel), .stat_frames(stat_frames)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (sched_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic handshake();
    sched_ready = 1'b1;
    tick();
    sched_ready = 1'b0;
  endtask

  function automatic int model_pick(input logic [NQ-1:0] elig);
    for (int i = 0; i < NQ; i++)
      if (elig[(m_rr + i) % NQ]) return (m_rr + i) % NQ;
    return -1;
  endfunction

  function automatic logic [NQ-1:0] onehot(input int q);
    logic [NQ-1:0] g;
    g = '0;
    g[q] = 1'b1;
    return g;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    total += 6;
    if (sched_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sched_valid); end
    if (sched_qid !== '0) begin bad++; $display("FAIL reset_qid got=%0d exp=0", sched_qid); end
    if (grant !== '0) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (underrun_abort !== 1'b0) begin bad++; $display("FAIL reset_abort got=%b exp=0", underrun_abort); end
    if (err_proto !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_proto); end
    reset_n = 1'b1;
    m_rr = 0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    q_enable = 4'hF; q_pending = 4'b0101; sched_ready = 1'b1;
    tick();
    total++;
    if (sched_valid !== 1'b1 || sched_qid !== QW'(model_pick(4'b0101))) begin
      bad++; $display("FAIL basic_offer0 got=%b/%0d exp=1/%0d", sched_valid, sched_qid, model_pick(4'b0101));
    end
    tick();
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL basic_grant0 got=%b exp=0001", grant); end
    frame_done = 1'b1; q_pending = 4'b0100;
    tick();
    frame_done = 1'b0;
    m_rr = 1;
    total++;
    if (grant !== 4'b0000) begin bad++; $display("FAIL basic_grant_release got=%b exp=0000", grant); end
    wait_valid(ok);
    total++;
    if (!ok || sched_qid !== QW'(model_pick(4'b0100))) begin
      bad++; $display("FAIL basic_offer2 got=%b/%0d exp=1/2", ok, sched_qid);
    end
    tick();
    total++;
    if (grant !== 4'b0100) begin bad++; $display("FAIL basic_grant2 got=%b exp=0100", grant); end
    frame_done = 1'b1; q_pending = 4'b0000; sched_ready = 1'b0;
    tick();
    frame_done = 1'b0;
    m_rr = 3;
    repeat (IFG_CYCLES + 3) tick();
  endtask

  task automatic test_quantum();
    bit ok;
    int n;
    q_enable = 4'hF; q_pending = 4'b0010;
    for (int f = 0; f < 6; f++) begin
      wait_valid(ok);
      total++;
      if (!ok || sched_qid !== QW'(model_pick(4'b0010))) begin
        bad++; $display("FAIL quantum_offer f=%0d got=%b/%0d exp=1/1", f, ok, sched_qid);
      end
      handshake();
      total++;
      if (grant !== 4'b0010) begin bad++; $display("FAIL quantum_grant f=%0d got=%b exp=0010", f, grant); end
      repeat ($urandom_range(0, 2)) tick();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      if (f == QUANTUM - 1) begin
        m_rr = 2;
        total++;
        if (sched_valid !== 1'b0 || grant !== 4'b0000) begin
          bad++; $display("FAIL quantum_turn_end got=%b/%b exp=0/0000", sched_valid, grant);
        end
        n = 0;
        while (!sched_valid && n < 20) begin n++; tick(); end
        total++;
        if (n != IFG_CYCLES + 2) begin bad++; $display("FAIL quantum_gap got=%0d exp=%0d", n, IFG_CYCLES + 2); end
      end else begin
        total++;
        if (sched_valid !== 1'b1 || grant !== 4'b0000) begin
          bad++; $display("FAIL quantum_reoffer f=%0d got=%b/%b exp=1/0000", f, sched_valid, grant);
        end
      end
    end
    q_pending = 4'b0000;
    tick();
    total++;
    if (sched_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL quantum_withdraw got=%b/%b exp=0/0", sched_valid, busy);
    end
  endtask

  task automatic test_underrun();
    bit ok;
    q_pending = 4'b1000;
    wait_valid(ok);
    total++;
    if (!ok || sched_qid !== QW'(model_pick(4'b1000))) begin
      bad++; $display("FAIL underrun_offer got=%b/%0d exp=1/3", ok, sched_qid);
    end
    handshake();
    for (int u = 0; u < MAX_RETRY; u++) begin
      tick();
      frame_underrun = 1'b1;
      tick();
      frame_underrun = 1'b0;
      total++;
      if (u < MAX_RETRY - 1) begin
        if (underrun_abort !== 1'b0 || grant !== 4'b1000) begin
          bad++; $display("FAIL underrun_retry u=%0d got=%b/%b exp=0/1000", u, underrun_abort, grant);
        end
      end else if (underrun_abort !== 1'b1 || grant !== 4'b0000) begin
        bad++; $display("FAIL underrun_abort got=%b/%b exp=1/0000", underrun_abort, grant);
      end
    end
    m_rr = 0;
    q_pending = 4'b1001;
    tick();
    total++;
    if (underrun_abort !== 1'b0) begin bad++; $display("FAIL underrun_pulse_width got=%b exp=0", underrun_abort); end
    wait_valid(ok);
    total++;
    if (!ok || sched_qid !== QW'(model_pick(4'b1001))) begin
      bad++; $display("FAIL underrun_rr got=%b/%0d exp=1/%0d", ok, sched_qid, model_pick(4'b1001));
    end
    q_pending = 4'b0000;
    tick();
  endtask

  task automatic test_withdraw();
    bit ok;
    q_pending = 4'b0100;
    wait_valid(ok);
    repeat (2) tick();
    total++;
    if (!ok || sched_valid !== 1'b1 || sched_qid !== 2'd2) begin
      bad++; $display("FAIL withdraw_hold got=%b/%0d exp=1/2", sched_valid, sched_qid);
    end
    q_pending = 4'b0000;
    tick();
    total++;
    if (sched_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL withdraw_drop got=%b/%b exp=0/0", sched_valid, busy);
    end
    q_pending = 4'b1100;
    wait_valid(ok);
    total++;
    if (!ok || sched_qid !== QW'(model_pick(4'b1100))) begin
      bad++; $display("FAIL withdraw_rr got=%b/%0d exp=1/%0d", ok, sched_qid, model_pick(4'b1100));
    end
    sched_ready = 1'b1; q_pending = 4'b0000;
    tick();
    sched_ready = 1'b0;
    total++;
    if (grant !== 4'b0100) begin bad++; $display("FAIL withdraw_ready_wins got=%b exp=0100", grant); end
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    m_rr = 3;
    total++;
    if (grant !== 4'b0000 || sched_valid !== 1'b0) begin
      bad++; $display("FAIL withdraw_turn_end got=%b/%b exp=0000/0", grant, sched_valid);
    end
    repeat (IFG_CYCLES + 3) tick();
  endtask

  task automatic test_err();
    bit ok;
    total++;
    if (err_proto !== 1'b0) begin bad++; $display("FAIL err_initial got=%b exp=0", err_proto); end
    q_pending = 4'b0010;
    wait_valid(ok);
    total++;
    if (!ok || sched_qid !== QW'(model_pick(4'b0010))) begin
      bad++; $display("FAIL err_offer got=%b/%0d exp=1/1", ok, sched_qid);
    end
    handshake();
    frame_done = 1'b1; frame_underrun = 1'b1; q_pending = 4'b0000;
    tick();
    frame_done = 1'b0; frame_underrun = 1'b0;
    m_rr = 2;
    total++;
    if (err_proto !== 1'b1 || underrun_abort !== 1'b0 || grant !== 4'b0000) begin
      bad++; $display("FAIL err_both got=%b/%b/%b exp=1/0/0000", err_proto, underrun_abort, grant);
    end
    repeat (IFG_CYCLES + 3) tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    repeat (3) tick();
    total++;
    if (err_proto !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL err_sticky got=%b/%b exp=1/0", err_proto, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    q_pending = 4'b0100;
    wait_valid(ok);
    handshake();
    total++;
    if (!ok || grant !== 4'b0100) begin bad++; $display("FAIL rstmid_grant got=%b exp=0100", grant); end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (grant !== '0 || busy !== 1'b0 || sched_valid !== 1'b0 || err_proto !== 1'b0 || underrun_abort !== 1'b0) begin
      bad++; $display("FAIL rstmid_async got=%b/%b/%b/%b exp=0000/0/0/0", grant, busy, sched_valid, err_proto);
    end
    tick(); tick();
    reset_n = 1'b1;
    m_rr = 0;
    q_pending = 4'b1111;
    wait_valid(ok);
    total++;
    if (!ok || sched_qid !== QW'(model_pick(4'b1111))) begin
      bad++; $display("FAIL rstmid_first got=%b/%0d exp=1/0", ok, sched_qid);
    end
    q_pending = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    bit ok, turn_over, abort;
    int exp_q, burst, k, nu;
    logic [NQ-1:0] elig;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_rr = 0;
    for (int q = 0; q < NQ; q++) m_frames[q] = 0;
    for (int ep = 0; ep < 6; ep++) begin
      q_enable = NQ'($urandom);
      q_pending = NQ'($urandom);
      k = $urandom_range(0, NQ - 1);
      if ((q_enable & q_pending) == '0) begin q_enable[k] = 1'b1; q_pending[k] = 1'b1; end
      elig = q_enable & q_pending;
      for (int t = 0; t < 3; t++) begin
        exp_q = model_pick(elig);
        burst = 0;
        turn_over = 1'b0;
        while (!turn_over) begin
          wait_valid(ok);
          total++;
          if (!ok || sched_qid !== QW'(exp_q)) begin
            bad++; $display("FAIL rand_offer ep=%0d got=%b/%0d exp=1/%0d", ep, ok, sched_qid, exp_q);
          end
          repeat ($urandom_range(0, 3)) tick();
          handshake();
          total++;
          if (grant !== onehot(exp_q)) begin
            bad++; $display("FAIL rand_grant ep=%0d got=%b exp=%b", ep, grant, onehot(exp_q));
          end
          k = $urandom_range(0, 4);
          abort = (k >= MAX_RETRY);
          nu = abort ? MAX_RETRY : k;
          for (int u = 0; u < nu; u++) begin
            repeat ($urandom_range(0, 2)) tick();
            frame_underrun = 1'b1;
            tick();
            frame_underrun = 1'b0;
            total++;
            if (abort && u == nu - 1) begin
              turn_over = 1'b1;
              if (underrun_abort !== 1'b1 || grant !== '0) begin
                bad++; $display("FAIL rand_abort got=%b/%b exp=1/0000", underrun_abort, grant);
              end
            end else if (underrun_abort !== 1'b0 || grant !== onehot(exp_q)) begin
              bad++; $display("FAIL rand_retry got=%b/%b exp=0/%b", underrun_abort, grant, onehot(exp_q));
            end
          end
          if (!abort) begin
            repeat ($urandom_range(0, 2)) tick();
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
            m_frames[exp_q]++;
            burst++;
            if (burst >= QUANTUM) turn_over = 1'b1;
            total++;
            if (sched_valid !== !turn_over) begin
              bad++; $display("FAIL rand_after_done burst=%0d got=%b exp=%b", burst, sched_valid, !turn_over);
            end
          end
        end
        m_rr = (exp_q + 1) % NQ;
      end
      q_pending = '0;
      repeat (IFG_CYCLES + 4) tick();
      total++;
      if (busy !== 1'b0 || sched_valid !== 1'b0) begin
        bad++; $display("FAIL rand_idle ep=%0d got=%b/%b exp=0/0", ep, busy, sched_valid);
      end
    end
`ifdef TX_SCHED_STATS_EN
    for (int q = 0; q < NQ; q++) begin
      stat_sel = QW'(q);
      tick(); tick();
      total++;
      if (stat_frames !== 32'(m_frames[q])) begin
        bad++; $display("FAIL rand_stats q=%0d got=%0d exp=%0d", q, stat_frames, m_frames[q]);
      end
    end
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_quantum();
    test_underrun();
    test_withdraw();
    test_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
